uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLOCKS_PER_BIT, default 4, meaning clk cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port rx_i  input  1  serial line, idle high, asynchronous to clk.
REQ-005 SHALL have port data_o  output  8  last correctly framed byte.
REQ-006 SHALL have port valid_o  output  1  one-cycle pulse when data_o is updated.
REQ-007 SHALL have port frame_err_o  output  1  one-cycle pulse on a bad stop bit.
REQ-008 SHALL have port busy_o  output  1  high whenever the state is not IDLE.
REQ-009 SHALL have port sum_o  output  32  running byte checksum; present only under UART_RX_CHECKSUM_EN.

Function
REQ-010 SHALL pass rx_i through a 2-flop synchronizer reset to 1; all decoding SHALL use the synchronized value rx_s.
REQ-011 SHALL implement states IDLE, START, DATA, STOP and BREAK, with a bit-timer counter of width clog2(CLOCKS_PER_BIT)+1 and a 3-bit bit index.
REQ-012 IDLE: when rx_s==0, SHALL go to START and load the timer with CLOCKS_PER_BIT/2-1 (integer division).
REQ-013 START: when the timer reaches 0 it SHALL sample rx_s.
  - If the sample is 0, SHALL go to DATA, reload the timer with CLOCKS_PER_BIT-1 and clear the bit index.
  - If the sample is 1 (glitch), SHALL return to IDLE with no output pulse.
REQ-014 DATA: on each timer expiry SHALL shift rx_s into the shift register LSB-first and reload the timer; after bit index 7 it SHALL go to STOP.
REQ-015 STOP: on timer expiry with rx_s==1, SHALL copy the shift register to data_o, pulse valid_o for exactly one cycle and go to IDLE.
REQ-016 STOP: on timer expiry with rx_s==0, SHALL pulse frame_err_o for one cycle, leave data_o unchanged and go to BREAK.
REQ-017 BREAK: SHALL remain in BREAK until rx_s==1, then go to IDLE; a new start bit is never detected while in BREAK.
REQ-018 valid_o SHALL rise in the cycle after the stop-bit sample edge.
REQ-019 valid_o and frame_err_o SHALL never be high in the same cycle.
REQ-020 Back-to-back frames with zero idle gap SHALL be received without loss, because IDLE detects the falling edge in the cycle after STOP exits.
REQ-021 rx_i changes while busy_o is high SHALL affect only the sampled bits; the state sequence above SHALL NOT be aborted.

Reset
REQ-022 While rst is high at a clk edge: state=IDLE, timer=0, bit index=0, shift register=0, data_o=0, valid_o=0, frame_err_o=0, synchronizer flops=1, sum_o=0.
REQ-023 Reset asserted mid-frame SHALL abandon the frame with no pulse, and the first frame after reset SHALL decode normally.

Configuration
REQ-024 SHALL use macro UART_RX_CHECKSUM_EN.
  - Defined: sum_o SHALL add data_o's new value, zero-extended, modulo 2^32, in the same cycle valid_o pulses; framing errors SHALL NOT change sum_o.
  - Undefined: the sum_o port and its adder SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-025 CLOCKS_PER_BIT=4, send 0x55 8N1 -> valid_o pulses once, data_o=0x55, frame_err_o stays 0.
REQ-026 Send 0x48, 0x69, 0x21 with no idle gap -> three valid_o pulses with data 0x48, 0x69, 0x21; under the macro sum_o=0x000000D2.
REQ-027 Drive rx_i low for 1 clk in IDLE -> busy_o drops back to 0 within CLOCKS_PER_BIT clk cycles, no pulses.
REQ-028 Send 0xA5 with stop bit 0, hold low 20 bits, release, then send 0x3C -> one frame_err_o pulse, data_o stays 0, then valid_o with data_o=0x3C.
REQ-029 Assert rst during data bit 4 of 0xFF, release, send 0x12 -> no pulse for 0xFF, data_o=0x12.
REQ-030 CLOCKS_PER_BIT=10, send 0x00 and 0xFF -> data_o=0x00 then 0xFF, each valid_o exactly one cycle wide.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver (8N1): 2-flop input synchronizer, mid-bit sampling, framing-error/break handling.
// Optional running byte checksum on sum_o when UART_RX_CHECKSUM_EN is defined.
module uart_rx #(
    parameter int unsigned CLOCKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_i,
    output logic [7:0]  data_o,
    output logic        valid_o,
    output logic        frame_err_o,
    output logic        busy_o
`ifdef UART_RX_CHECKSUM_EN
    ,
    output logic [31:0] sum_o
`endif
);

    localparam int unsigned TW = $clog2(CLOCKS_PER_BIT) + 1;
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CLOCKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic [1:0]      sync_q;
    logic            rx_s;
    logic            timer_done;

    assign rx_s       = sync_q[1];
    assign timer_done = (timer_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            sync_q    <= 2'b11;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            sync_q    <= {sync_q[0], rx_i};
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    timer_d = HALF_LOAD;
                end
            end
            START: begin
                if (timer_done) begin
                    // A line that is high again at mid-start-bit was only a glitch.
                    if (!rx_s) begin
                        state_d   = DATA;
                        timer_d   = FULL_LOAD;
                        bit_idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            DATA: begin
                if (timer_done) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    timer_d   = FULL_LOAD;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            STOP: begin
                if (timer_done) begin
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            BREAK: begin
                // Wait for the line to return high so a held-low line never looks like a start bit.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign busy_o      = (state_q != IDLE);

`ifdef UART_RX_CHECKSUM_EN
    logic [31:0] sum_q;

    // Accumulates on the same edge that raises valid_o, so both change together.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else if (valid_d) begin
            sum_q <= sum_q + {24'd0, data_d};
        end
    end

    assign sum_o = sum_q;
`endif

endmodule
